video_timing_pattern_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/key_debounce.sv | 39 +++
 rtl/video_timing_pattern_gen.sv | 107 ++++++++++
 tb/tb_video_timing_pattern_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 720p timing constants, colour-bar table and pattern enum
package video_timing_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  // Counters are kept this wide so the gradient pattern can always index h[10:3] / v[9:2]
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {PAT_BARS, PAT_GRID, PAT_GRAD, PAT_RED} pattern_e;

  // Colour bars left to right, packed {R,G,B}
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [3:0] pat_onehot(input pattern_e p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus level debouncer emitting a one-cycle press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 742500
) (
  input  logic pix_clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          hit;

  // Accept the new level on the last of DEBOUNCE_CYCLES consecutive differing samples
  always_comb hit = sync[1] != level && cnt == LAST;

  // Synchroniser, idles high like the released key
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], key_n};

  // Debounce counter, accepted level and press pulse on an accepted 1->0
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      cnt   <= (sync[1] == level || hit) ? '0 : cnt + CW'(1);
      level <= hit ? sync[1] : level;
      press <= hit && !sync[1];
    end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: raster timing with four selectable test patterns
module video_timing_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE        = H_ACTIVE_720P,
  parameter int H_FP            = H_FP_720P,
  parameter int H_SYNC          = H_SYNC_720P,
  parameter int H_BP            = H_BP_720P,
  parameter int V_ACTIVE        = V_ACTIVE_720P,
  parameter int V_FP            = V_FP_720P,
  parameter int V_SYNC          = V_SYNC_720P,
  parameter int V_BP            = V_BP_720P,
  parameter int DEBOUNCE_CYCLES = 742500
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  input  logic       turn_mode,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_DE,
  output logic [3:0] mode
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             press, pending, frame_start, advance, active;
  pattern_e         pat, pat_nx, pat_px;
  logic [2:0]       bar;
  logic [23:0]      pix, rgb_nx;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .pix_clk(pix_clk),
    .rst_n  (rst_n),
    .key_n  (turn_mode),
    .press  (press)
  );

  // Pixel for the current counter value; a switching frame uses the new pattern from its first pixel
  always_comb begin
    frame_start = h_cnt == '0 && v_cnt == '0;
    advance     = frame_start && pending;
    pat_nx      = pattern_e'(pat + 2'd1);
    pat_px      = advance ? pat_nx : pat;
    active      = h_cnt < H_ACT && v_cnt < V_ACT;
    bar         = '0;
    for (int i = 1; i < 8; i++)
      if (h_cnt >= CNT_W'(i * BAR_W)) bar = 3'(i);
    pix = pat_px == PAT_BARS ? BAR_RGB[bar] :
          pat_px == PAT_GRID ? ((h_cnt[4:0] == '0 || v_cnt[4:0] == '0) ? 24'hFFFFFF : 24'h000000) :
          pat_px == PAT_GRAD ? {h_cnt[10:3], v_cnt[9:2], 8'h80} :
                               24'hFF0000;
    rgb_nx = active ? pix : 24'h000000;
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + CNT_W'(1);
      if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + CNT_W'(1);
    end

  // Presses collect in a pending flag that is consumed only at frame start
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) begin
      pat     <= PAT_BARS;
      mode    <= 4'b0001;
      pending <= 1'b0;
    end else begin
      pending <= press || (pending && !frame_start);
      if (advance) begin
        pat  <= pat_nx;
        mode <= pat_onehot(pat_nx);
      end
    end

  // Registered video outputs, all one cycle behind the counters
  always_ff @(posedge pix_clk or negedge rst_n)
    if (!rst_n) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS <= 1'b0;
      VGA_VS <= 1'b0;
      VGA_DE <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= rgb_nx;
      VGA_HS <= h_cnt >= HS_ON && h_cnt < HS_OFF;
      VGA_VS <= v_cnt >= VS_ON && v_cnt < VS_OFF;
      VGA_DE <= active;
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: frame-level directed checks with a pixel scoreboard
module tb_video_timing_pattern_gen;

  logic       pix_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       turn_mode = 1'b1;
  logic [7:0] r, g, b;
  logic       hs, vs, de;
  logic [3:0] mode;

  typedef struct packed {
    logic [3:0]  mode;
    logic [23:0] rgb;
  } px_t;

  px_t  exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_press = 0;
  logic mon_en = 1'b0;

  localparam int NONE = 1000;

  always #5 pix_clk = ~pix_clk;

  video_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .pix_clk  (pix_clk),
    .rst_n    (rst_n),
    .turn_mode(turn_mode),
    .VGA_R    (r),
    .VGA_G    (g),
    .VGA_B    (b),
    .VGA_HS   (hs),
    .VGA_VS   (vs),
    .VGA_DE   (de),
    .mode     (mode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [3:0] m, input int x, input int y);
    case (m)
      4'b0001:
        case (x / 2)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      4'b0010: return (x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h000000;
      4'b0100: return {8'(x / 8), 8'(y / 4), 8'h80};
      default: return 24'hFF0000;
    endcase
  endfunction

  // Count press pulses inside the debouncer
  always @(negedge pix_clk)
    if (dut.u_key.press === 1'b1) n_press++;

  // Scoreboard monitor: each DE pixel pops one expectation, blanking must be black
  always @(negedge pix_clk)
    if (mon_en) begin
      if (de === 1'b1) begin
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          px_t e;
          e = exp_q.pop_front();
          check("pixel_rgb", {8'h0, r, g, b}, {8'h0, e.rgb});
          check("pixel_mode", {28'h0, mode}, {28'h0, e.mode});
        end
      end else check("blank_rgb", {8'h0, r, g, b}, 32'h0);
    end

  // One 192-cycle frame: queue expected pixels, drive key, tally sync/DE shape
  task automatic run_frame(input string tag, input logic [3:0] m, input int s0, input int s1,
                           input int s2, input int len, input int rst_at, input int exp_press);
    int hs_bad = 0, vs_bad = 0, de_bad = 0, hs_n = 0, vs_n = 0, de_n = 0;
    int c, h, v;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 16; x++) exp_q.push_back({m, exp_rgb(m, x, y)});
    for (int k = 1; k <= 192; k++) begin
      @(posedge pix_clk);
      #1;
      c = k - 1;
      h = c % 24;
      v = c / 24;
      if (hs !== (h >= 18 && h < 20)) hs_bad++;
      if (vs !== (v == 5)) vs_bad++;
      if (de !== (h < 16 && v < 4)) de_bad++;
      hs_n += int'(hs);
      vs_n += int'(vs);
      de_n += int'(de);
      if (k == s0 || k == s1 || k == s2) turn_mode = 1'b0;
      if (k == s0 + len || k == s1 + len || k == s2 + len) turn_mode = 1'b1;
      if (k == rst_at) begin
        check({tag, "_mode_before_rst"}, {28'h0, mode}, {28'h0, m});
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_rgb"}, {8'h0, r, g, b}, 32'h0);
        check({tag, "_rst_sync"}, {29'h0, hs, vs, de}, 32'h0);
        check({tag, "_rst_mode"}, {28'h0, mode}, 32'h1);
        return;
      end
    end
    check({tag, "_hs_pos"}, hs_bad, 0);
    check({tag, "_vs_pos"}, vs_bad, 0);
    check({tag, "_de_pos"}, de_bad, 0);
    check({tag, "_hs_cnt"}, hs_n, 16);
    check({tag, "_vs_cnt"}, vs_n, 24);
    check({tag, "_de_cnt"}, de_n, 64);
    check({tag, "_mode"}, {28'h0, mode}, {28'h0, m});
    check({tag, "_press_total"}, n_press, exp_press);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #12;
    check("reset_rgb", {8'h0, r, g, b}, 32'h0);
    check("reset_sync", {29'h0, hs, vs, de}, 32'h0);
    check("reset_mode", {28'h0, mode}, 32'h1);
    @(posedge pix_clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_frame("A", 4'b0001, NONE, NONE, NONE, 0, 0, 0);
    run_frame("B", 4'b0001, 50, NONE, NONE, 6, 0, 1);
    run_frame("C", 4'b0010, 50, NONE, NONE, 3, 0, 1);
    run_frame("D", 4'b0010, 20, 60, 100, 6, 0, 4);
    run_frame("E", 4'b0100, 50, NONE, NONE, 6, 0, 5);
    run_frame("F", 4'b1000, 50, NONE, NONE, 6, 0, 6);
    run_frame("G", 4'b0001, 186, NONE, NONE, 6, 0, 6);
    run_frame("H", 4'b0001, NONE, NONE, NONE, 0, 0, 7);
    run_frame("I", 4'b0010, 50, NONE, NONE, 6, 0, 8);
    run_frame("J", 4'b0100, NONE, NONE, NONE, 0, 30, 8);
    repeat (2) @(posedge pix_clk);
    #1;
    check("rst_hold_mode", {28'h0, mode}, 32'h1);
    exp_q.delete();
    rst_n = 1'b1;
    run_frame("K", 4'b0001, NONE, NONE, NONE, 0, 0, 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
